calc_core: RTL and testbench

CALC_CORE -- requirements
Module: calc_core

---
 rtl/calc_pkg.sv | 33 +++
 rtl/calc_alu.sv | 48 ++++
 rtl/calc_core.sv | 171 +++++++++++++++++
 tb/tb_calc_core.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg -- shared types for the calculator core.
//   calc_op_e    : operator key codes (ADD=0, SUB=1, MUL=2, DIV=3, NEG=4).
//   calc_state_e : calculator FSM states.
//   is_binop()   : true for opcodes that take two operands in this build.
// Build option: CALC_DIV_EN enables the DIV opcode. Without it DIV is an unused code.
package calc_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    NEG = 3'd4
  } calc_op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY_A = 3'd1,
    OP_SEL  = 3'd2,
    ENTRY_B = 3'd3,
    RESULT  = 3'd4,
    ERROR   = 3'd5
  } calc_state_e;

  function automatic logic is_binop(input logic [2:0] code);
`ifdef CALC_DIV_EN
    return (code == ADD) || (code == SUB) || (code == MUL) || (code == DIV);
`else
    return (code == ADD) || (code == SUB) || (code == MUL);
`endif
  endfunction

endpackage

// File: rtl/calc_alu.sv
// calc_alu -- combinational signed arithmetic for the calculator.
//   a_i, b_i : signed WIDTH-bit operands
//   op_i     : operator (ADD/SUB/MUL, DIV only when CALC_DIV_EN is defined)
//   res_o    : WIDTH-bit result (meaningful only when ovf_o=0)
//   ovf_o    : result outside +/-(2^(WIDTH-1)-1), or divide by zero
// Build option: CALC_DIV_EN adds a signed divider (truncating toward zero).
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  calc_op_e                op_i,
  output logic signed [WIDTH-1:0] res_o,
  output logic                    ovf_o
);

  localparam int WW = 2 * WIDTH;
  // Symmetric range: -2^(WIDTH-1) is excluded so every result has a displayable magnitude.
  localparam logic signed [WW-1:0] LIMIT = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};

  logic signed [WW-1:0] a_w;
  logic signed [WW-1:0] b_w;
  logic signed [WW-1:0] wide;

  always_comb begin
    a_w   = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    b_w   = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    wide  = '0;
    ovf_o = 1'b0;
    case (op_i)
      ADD:     wide = a_w + b_w;
      SUB:     wide = a_w - b_w;
      MUL:     wide = a_w * b_w;
`ifdef CALC_DIV_EN
      DIV: begin
        if (b_w == '0) ovf_o = 1'b1;
        else           wide  = a_w / b_w;
      end
`endif
      default: wide = '0;
    endcase
    if ((wide > LIMIT) || (wide < -LIMIT)) ovf_o = 1'b1;
    res_o = wide[WIDTH-1:0];
  end

endmodule

// File: rtl/calc_core.sv
// calc_core -- keypad calculator: decimal entry, one binary op, enter, chaining.
//   clk, nrst          : clock (rising edge), asynchronous active-low reset
//   key_strobe         : qualifies is_dig/digit, is_op/opcode, is_enter, is_clear
//                        (priority clear > enter > op > digit)
//   disp_mag, disp_neg : display magnitude and sign (registered)
//   err                : high while in ERROR
//   result_valid       : one-cycle pulse, the cycle after an enter produces a result
//   dbg_state          : current FSM state, for observation only
// Handshake: a key is consumed on every clk edge where key_strobe=1; there is no
// back-pressure. result_valid has no ready: it is a pulse that coincides with the
// display first showing the new result.
// Build option: CALC_DIV_EN enables the DIV opcode.
module calc_core
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             key_strobe,
  input  logic             is_dig,
  input  logic [3:0]       digit,
  input  logic             is_op,
  input  logic [2:0]       opcode,
  input  logic             is_enter,
  input  logic             is_clear,
  output logic [WIDTH-2:0] disp_mag,
  output logic             disp_neg,
  output logic             err,
  output logic             result_valid,
  output calc_state_e      dbg_state
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  calc_state_e             state_q, state_d;
  calc_op_e                op_q, op_d;
  logic signed [WIDTH-1:0] entry_q, entry_d;
  logic signed [WIDTH-1:0] a_q, a_d;
  logic signed [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]           count_q, count_d;
  logic [WIDTH-2:0]        disp_mag_q, disp_mag_d;
  logic                    disp_neg_q, disp_neg_d;
  logic                    err_q, err_d;
  logic                    rv_q, rv_d;

  logic signed [WIDTH-1:0] alu_res;
  logic                    alu_ovf;
  logic signed [WIDTH-1:0] disp_val;

  // B is always the live entry; the ALU result is only used on enter in ENTRY_B.
  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i   (a_q),
    .b_i   (entry_q),
    .op_i  (op_q),
    .res_o (alu_res),
    .ovf_o (alu_ovf)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    entry_d  = entry_q;
    a_d      = a_q;
    result_d = result_q;
    count_d  = count_q;
    rv_d     = 1'b0;

    if (key_strobe) begin
      if (is_clear) begin
        state_d  = IDLE;
        op_d     = ADD;
        entry_d  = '0;
        a_d      = '0;
        result_d = '0;
        count_d  = '0;
      end else if (is_enter) begin
        if (state_q == ENTRY_A) begin
          result_d = entry_q;
          state_d  = RESULT;
          rv_d     = 1'b1;
        end else if (state_q == ENTRY_B) begin
          if (alu_ovf) begin
            state_d = ERROR;
          end else begin
            result_d = alu_res;
            state_d  = RESULT;
            rv_d     = 1'b1;
          end
        end
      end else if (is_op) begin
        if (opcode == NEG) begin
          if ((state_q == ENTRY_A) || (state_q == ENTRY_B)) entry_d = -entry_q;
        end else if (is_binop(opcode)) begin
          case (state_q)
            ENTRY_A, RESULT: begin
              // Chaining from RESULT reuses the last result as the new A.
              a_d     = (state_q == RESULT) ? result_q : entry_q;
              op_d    = calc_op_e'(opcode);
              entry_d = '0;
              count_d = '0;
              state_d = OP_SEL;
            end
            OP_SEL:  op_d = calc_op_e'(opcode);
            default: ;
          endcase
        end
      end else if (is_dig && (digit <= 4'd9)) begin
        case (state_q)
          IDLE, OP_SEL, RESULT: begin
            entry_d = WIDTH'(digit);
            count_d = CW'(1);
            state_d = (state_q == OP_SEL) ? ENTRY_B : ENTRY_A;
          end
          ENTRY_A, ENTRY_B: begin
            if (count_q != CW'(MAX_DIGITS)) begin
              entry_d = entry_q * WIDTH'(10) + WIDTH'(digit);
              count_d = count_q + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end

    // Display follows the next state so it lands together with result_valid.
    case (state_d)
      ENTRY_A, ENTRY_B: disp_val = entry_d;
      OP_SEL:           disp_val = a_d;
      RESULT:           disp_val = result_d;
      default:          disp_val = '0;
    endcase
    disp_neg_d = disp_val[WIDTH-1];
    disp_mag_d = disp_neg_d ? (WIDTH-1)'(-disp_val) : disp_val[WIDTH-2:0];
    err_d      = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      op_q       <= ADD;
      entry_q    <= '0;
      a_q        <= '0;
      result_q   <= '0;
      count_q    <= '0;
      disp_mag_q <= '0;
      disp_neg_q <= 1'b0;
      err_q      <= 1'b0;
      rv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      entry_q    <= entry_d;
      a_q        <= a_d;
      result_q   <= result_d;
      count_q    <= count_d;
      disp_mag_q <= disp_mag_d;
      disp_neg_q <= disp_neg_d;
      err_q      <= err_d;
      rv_q       <= rv_d;
    end
  end

  assign disp_mag     = disp_mag_q;
  assign disp_neg     = disp_neg_q;
  assign err          = err_q;
  assign result_valid = rv_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core -- bench for calc_core (WIDTH=16, MAX_DIGITS=4).
// Follows CALC_DIV_EN: with it defined DIV is expected to divide, otherwise to be ignored.
module tb_calc_core;
  import calc_pkg::*;

  localparam int     W    = 16;
  localparam int     MAXD = 4;
  localparam longint LIM  = (longint'(1) << (W - 1)) - 1;
`ifdef CALC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         key_strobe = 1'b0, is_dig = 1'b0, is_op = 1'b0, is_enter = 1'b0, is_clear = 1'b0;
  logic [3:0]   digit = '0;
  logic [2:0]   opcode = '0;
  logic [W-2:0] disp_mag;
  logic         disp_neg, err, result_valid;
  calc_state_e  dbg_state;

  always #5 clk = ~clk;

  calc_core #(.WIDTH(W), .MAX_DIGITS(MAXD)) dut (
    .clk(clk), .nrst(nrst), .key_strobe(key_strobe),
    .is_dig(is_dig), .digit(digit), .is_op(is_op), .opcode(opcode),
    .is_enter(is_enter), .is_clear(is_clear),
    .disp_mag(disp_mag), .disp_neg(disp_neg), .err(err),
    .result_valid(result_valid), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input longint v);
    longint m;
    logic [W-2:0] mg;
    m  = (v < 0) ? -v : v;
    mg = (W-1)'(m);
    return {(v < 0), mg};
  endfunction

  // Monitor: every result_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (nrst && result_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL result_pulse: got unexpected pulse disp=%0d expected none", disp_mag);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", longint'({disp_neg, disp_mag}), longint'(mon_e));
      end
    end
  end

  // ---------------- reference model ----------------
  calc_state_e m_st;
  longint      m_ent, m_a, m_res;
  int          m_cnt, m_op;

  task automatic model_reset();
    m_st = IDLE; m_ent = 0; m_a = 0; m_res = 0; m_cnt = 0; m_op = 0;
  endtask

  task automatic model_key(input bit s, input bit c, input bit e, input bit o, input int code,
                           input bit dg, input int d, output bit rv_exp);
    longint r;
    bit     bad;
    rv_exp = 1'b0;
    if (!s) return;
    if (c) begin
      model_reset();
    end else if (e) begin
      if (m_st == ENTRY_A) begin
        m_res = m_ent; m_st = RESULT; rv_exp = 1'b1;
        exp_q.push_back(pack(m_res));
      end else if (m_st == ENTRY_B) begin
        bad = 1'b0; r = 0;
        case (m_op)
          0: r = m_a + m_ent;
          1: r = m_a - m_ent;
          2: r = m_a * m_ent;
          default: if (m_ent == 0) bad = 1'b1; else r = m_a / m_ent;
        endcase
        if (bad || r > LIM || r < -LIM) m_st = ERROR;
        else begin
          m_res = r; m_st = RESULT; rv_exp = 1'b1;
          exp_q.push_back(pack(m_res));
        end
      end
    end else if (o) begin
      if (code == 4) begin
        if (m_st == ENTRY_A || m_st == ENTRY_B) m_ent = -m_ent;
      end else if (code <= 2 || (code == 3 && DIV_EN)) begin
        if (m_st == ENTRY_A) begin
          m_a = m_ent; m_op = code; m_st = OP_SEL;
        end else if (m_st == RESULT) begin
          m_a = m_res; m_op = code; m_st = OP_SEL;
        end else if (m_st == OP_SEL) begin
          m_op = code;
        end
      end
    end else if (dg && d <= 9) begin
      if (m_st == IDLE || m_st == RESULT) begin
        m_ent = d; m_cnt = 1; m_st = ENTRY_A;
      end else if (m_st == OP_SEL) begin
        m_ent = d; m_cnt = 1; m_st = ENTRY_B;
      end else if ((m_st == ENTRY_A || m_st == ENTRY_B) && m_cnt < MAXD) begin
        m_ent = m_ent * 10 + d; m_cnt++;
      end
    end
  endtask

  function automatic longint model_disp();
    case (m_st)
      ENTRY_A, ENTRY_B: return m_ent;
      OP_SEL:           return m_a;
      RESULT:           return m_res;
      default:          return 0;
    endcase
  endfunction

  task automatic check_outputs(input bit rv_exp);
    longint v;
    v = model_disp();
    check("disp_mag", longint'(disp_mag), (v < 0) ? -v : v);
    check("disp_neg", longint'(disp_neg), longint'(v < 0));
    check("err", longint'(err), longint'(m_st == ERROR));
    check("state", longint'(dbg_state), longint'(m_st));
    check("result_valid", longint'(result_valid), longint'(rv_exp));
  endtask

  // ---------------- driver tasks (entered at a falling edge) ----------------
  task automatic press(input bit s, input bit c, input bit e, input bit o, input int code,
                       input bit dg, input int d);
    bit rv_e;
    key_strobe = s; is_clear = c; is_enter = e; is_op = o; opcode = 3'(code);
    is_dig = dg; digit = 4'(d);
    model_key(s, c, e, o, code, dg, d, rv_e);
    @(negedge clk);
    key_strobe = 1'b0; is_clear = 1'b0; is_enter = 1'b0; is_op = 1'b0; is_dig = 1'b0;
    check_outputs(rv_e);
  endtask

  task automatic dig(input int d);  press(1, 0, 0, 0, 0, 1, d); endtask
  task automatic op(input int c);   press(1, 0, 0, 1, c, 0, 0); endtask
  task automatic ent();             press(1, 0, 1, 0, 0, 0, 0); endtask
  task automatic clr();             press(1, 1, 0, 0, 0, 0, 0); endtask
  task automatic idle();            press(0, 0, 0, 0, 0, 0, 0); endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #3;
    check_outputs(1'b0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    // 12 + 3 = 15, pulse one cycle after the enter strobe, then low
    dig(1); dig(2); op(0); dig(3); ent(); idle();

    // fifth digit ignored -> 5678; out-of-range digit ignored
    clr(); dig(5); dig(6); dig(7); dig(8); dig(9); dig(11);

    // 7 - 9 = -2, chain * 3 = -6
    clr(); dig(7); op(1); dig(9); ent(); op(2); dig(3); ent();

    // op replacement in OP_SEL, enter there ignored, unused opcodes ignored
    clr(); dig(4); op(2); op(0); ent(); op(6); dig(6); ent();

    // overflow into ERROR, digit ignored, clear leaves
    clr();
    repeat (4) dig(9);
    op(2);
    repeat (4) dig(9);
    ent(); dig(3); op(0); ent(); clr();

    // -7 DIV 2 and 5 DIV 0 (DIV ignored when the divider is not built)
    dig(7); op(4); op(3); dig(2); ent();
    clr(); dig(5); op(3); dig(0); ent(); clr();

    // enter on a single operand, negate, -0
    dig(0); op(4); ent(); dig(3); op(4); ent();

    // strobe low with all flags set; priority clear > enter > op > digit
    dig(2); press(0, 1, 1, 1, 2, 1, 5);
    press(1, 0, 1, 1, 2, 1, 5);
    press(1, 0, 0, 1, 0, 1, 5);
    press(1, 1, 1, 1, 0, 1, 5);

    // randomized key stream, several flags at once
    for (int i = 0; i < 400; i++) begin
      press(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 12),
            ($urandom_range(0, 99) < 25), int'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 70), int'($urandom_range(0, 11)));
    end

    // asynchronous reset in the middle of ENTRY_B with a key strobe active
    clr(); dig(4); op(0); dig(2);
    key_strobe = 1'b1; is_dig = 1'b1; digit = 4'd7;
    #2 nrst = 1'b0;
    #1;
    model_reset();
    check_outputs(1'b0);
    @(negedge clk);
    key_strobe = 1'b0; is_dig = 1'b0;
    check_outputs(1'b0);
    nrst = 1'b1;
    dig(3); ent(); idle();

    check("exp_q_drained", longint'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
